// File: rtl/aes128_inv_sbox_pipe.sv
// -----------------------------------------------------------------------------
// aes128_inv_sbox_pipe
//   Three-stage pipelined inverse-SubBytes for the AES decryption round.
//   Every byte lane applies the inverse affine map and then inverts in
//   GF(2^8). The inversion runs in the tower field GF((2^4)^2), using
//   GF(2^4) mod x^4+x+1 and x^2+x+lambda with lambda = 0xC.
//   Valid/ready handshakes on both sides. Pipeline bubbles collapse.
//
//   Optional build macro AES128_INV_SBOX_FWD_EN adds the in_fwd port.
//   When in_fwd=1 the word skips the inverse affine and gets the forward
//   affine (+0x63) on exit, so the lane produces the forward S-box. The
//   mode bit travels down the pipe with its word.
//
// Ports (top):
//   in_clock  : clock, rising edge
//   in_reset  : synchronous active-high reset
//   in_valid  : upstream word valid
//   out_ready : unit accepts a word this cycle (combinational)
//   in_data   : NUM_BYTES input bytes, byte i = in_data[8i+7:8i]
//   in_fwd    : (macro only) 1 = forward S-box for this word
//   out_valid : result valid
//   in_ready  : downstream accepts the result this cycle
//   out_data  : result bytes, same lane order
// -----------------------------------------------------------------------------

// One byte lane: datapath registers of all three stages.
// Ports: clk_i/rst_i clock and sync reset, en_i[k] loads stage k+1,
//        fwd_s1_i / fwd_s3_i mode of the word entering S1 / S3,
//        byte_i input byte, byte_o registered result byte.
module aes128_inv_sbox_lane (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] en_i,
    input  logic       fwd_s1_i,
    input  logic       fwd_s3_i,
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);
    localparam logic [3:0] LAMBDA = 4'hC;

    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    // Shared GF(2^4) inverter. inv(0) = 0, so a zero byte needs no special case.
    function automatic logic [3:0] gf4_inv(input logic [3:0] a);
        logic [3:0] r;
        case (a)
            4'h1: r = 4'h1;  4'h2: r = 4'h9;  4'h3: r = 4'hE;  4'h4: r = 4'hD;
            4'h5: r = 4'hB;  4'h6: r = 4'h7;  4'h7: r = 4'h6;  4'h8: r = 4'hF;
            4'h9: r = 4'h2;  4'hA: r = 4'hC;  4'hB: r = 4'h5;  4'hC: r = 4'hA;
            4'hD: r = 4'h4;  4'hE: r = 4'h3;  4'hF: r = 4'h8;
            default: r = 4'h0;
        endcase
        return r;
    endfunction

    // Tower-field product, with x^2 = x + lambda. Used only to build the basis maps.
    function automatic logic [7:0] t_mul(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] hh;
        hh = gf4_mul(a[7:4], b[7:4]);
        return {hh ^ gf4_mul(a[7:4], b[3:0]) ^ gf4_mul(a[3:0], b[7:4]),
                gf4_mul(hh, LAMBDA) ^ gf4_mul(a[3:0], b[3:0])};
    endfunction

    // GF(2) linear map given by its 8 column bytes (column i = image of bit i).
    function automatic logic [7:0] lin(input logic [63:0] cols, input logic [7:0] x);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            if (x[i]) r = r ^ cols[8*i +: 8];
        return r;
    endfunction

    // Polynomial -> tower basis. Find a tower element beta that is a root of
    // x^8+x^4+x^3+x+1, then map x^i to beta^i. Any root gives a valid
    // isomorphism, and the S-box result does not depend on the root chosen.
    function automatic logic [63:0] calc_fwd_map();
        logic [63:0] cols;
        logic [7:0]  pw;
        logic        found;
        cols  = '0;
        found = 1'b0;
        for (int c = 1; c < 256; c++) begin
            if (!found) begin
                pw = 8'h01;
                for (int i = 0; i < 8; i++) begin
                    cols[8*i +: 8] = pw;
                    pw = t_mul(pw, 8'(c));
                end
                if ((pw ^ cols[39:32] ^ cols[31:24] ^ cols[15:8] ^ cols[7:0]) == 8'h00)
                    found = 1'b1;
            end
        end
        return cols;
    endfunction

    // Inverse basis change, found by searching for the preimage of each unit vector.
    function automatic logic [63:0] calc_inv_map(input logic [63:0] fwd);
        logic [63:0] inv;
        inv = '0;
        for (int q = 0; q < 256; q++)
            for (int j = 0; j < 8; j++)
                if (lin(fwd, 8'(q)) == (8'h01 << j)) inv[8*j +: 8] = 8'(q);
        return inv;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    localparam logic [63:0] MAP     = calc_fwd_map();
    localparam logic [63:0] INV_MAP = calc_inv_map(MAP);

    logic [3:0] ah1_q, al1_q, d1_q;
    logic [3:0] ah2_q, al2_q, di2_q;
    logic [7:0] out_q;

    logic [7:0] y1, t1, b3;
    logic [3:0] d1_d, di2_d, oh3, ol3;
    logic [7:0] out_d;

    always_comb begin
        // S1: affine (or identity for forward mode), basis change, norm d
        y1   = fwd_s1_i ? byte_i : inv_affine(byte_i);
        t1   = lin(MAP, y1);
        d1_d = gf4_mul(gf4_mul(t1[7:4], t1[7:4]), LAMBDA)
             ^ gf4_mul(t1[7:4], t1[3:0])
             ^ gf4_mul(t1[3:0], t1[3:0]);
        // S2: invert the norm
        di2_d = gf4_inv(d1_q);
        // S3: (ah*x + al)^-1 = ah*d^-1 * x + (ah^al)*d^-1, then back to polynomial basis
        oh3   = gf4_mul(ah2_q, di2_q);
        ol3   = gf4_mul(ah2_q ^ al2_q, di2_q);
        b3    = lin(INV_MAP, {oh3, ol3});
        out_d = fwd_s3_i ? fwd_affine(b3) : b3;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ah1_q <= '0; al1_q <= '0; d1_q  <= '0;
            ah2_q <= '0; al2_q <= '0; di2_q <= '0;
            out_q <= '0;
        end else begin
            if (en_i[0]) begin
                ah1_q <= t1[7:4];
                al1_q <= t1[3:0];
                d1_q  <= d1_d;
            end
            if (en_i[1]) begin
                ah2_q <= ah1_q;
                al2_q <= al1_q;
                di2_q <= di2_d;
            end
            if (en_i[2]) out_q <= out_d;
        end
    end

    assign byte_o = out_q;
endmodule

module aes128_inv_sbox_pipe #(
    parameter int NUM_BYTES = 4
) (
    input  logic                   in_clock,
    input  logic                   in_reset,
    input  logic                   in_valid,
    output logic                   out_ready,
`ifdef AES128_INV_SBOX_FWD_EN
    input  logic                   in_fwd,
`endif
    input  logic [8*NUM_BYTES-1:0] in_data,
    output logic                   out_valid,
    input  logic                   in_ready,
    output logic [8*NUM_BYTES-1:0] out_data
);
    logic [3:1] vld_q, vld_d;
    logic       adv1, adv2, adv3;
    logic [2:0] en;
    logic       fwd_s1, fwd_s3;

    // A stage loads when the stage after it is empty or is moving on. Data
    // enables also need a valid source, so held or empty stages keep their contents.
    always_comb begin
        adv3  = !vld_q[3] | in_ready;
        adv2  = !vld_q[2] | adv3;
        adv1  = !vld_q[1] | adv2;
        vld_d = vld_q;
        if (adv1) vld_d[1] = in_valid;
        if (adv2) vld_d[2] = vld_q[1];
        if (adv3) vld_d[3] = vld_q[2];
        en    = {adv3 & vld_q[2], adv2 & vld_q[1], adv1 & in_valid};
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) vld_q <= '0;
        else          vld_q <= vld_d;
    end

`ifdef AES128_INV_SBOX_FWD_EN
    logic fwd1_q, fwd2_q;
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            fwd1_q <= 1'b0;
            fwd2_q <= 1'b0;
        end else begin
            if (en[0]) fwd1_q <= in_fwd;
            if (en[1]) fwd2_q <= fwd1_q;
        end
    end
    assign fwd_s1 = in_fwd;
    assign fwd_s3 = fwd2_q;
`else
    assign fwd_s1 = 1'b0;
    assign fwd_s3 = 1'b0;
`endif

    aes128_inv_sbox_lane u_lane [NUM_BYTES-1:0] (
        .clk_i    (in_clock),
        .rst_i    (in_reset),
        .en_i     (en),
        .fwd_s1_i (fwd_s1),
        .fwd_s3_i (fwd_s3),
        .byte_i   (in_data),
        .byte_o   (out_data)
    );

    assign out_ready = adv1;
    assign out_valid = vld_q[3];
endmodule

// File: tb/tb_aes128_inv_sbox_pipe.sv
module tb_aes128_inv_sbox_pipe;
    localparam int NB = 4;
    localparam int DW = 8 * NB;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_ready, out_valid;
    logic [DW-1:0] in_data, out_data;
`ifdef AES128_INV_SBOX_FWD_EN
    logic          in_fwd;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] sbox_t  [256];
    logic [7:0] isbox_t [256];

    always #5 clk = ~clk;

    aes128_inv_sbox_pipe #(.NUM_BYTES(NB)) dut (
        .in_clock  (clk),
        .in_reset  (rst),
        .in_valid  (in_valid),
        .out_ready (out_ready),
`ifdef AES128_INV_SBOX_FWD_EN
        .in_fwd    (in_fwd),
`endif
        .in_data   (in_data),
        .out_valid (out_valid),
        .in_ready  (in_ready),
        .out_data  (out_data)
    );

    // Reference: plain GF(2^8) arithmetic mod 0x11B, brute-force inverse, affine by rotations
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 0; aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic int rotl(input int v, input int k);
        return ((v << k) | (v >> (8 - k))) & 255;
    endfunction

    task automatic build_tables();
        for (int b = 0; b < 256; b++) begin
            int inv, s;
            inv = 0;
            for (int c = 1; c < 256; c++)
                if (gmul(8'(b), 8'(c)) == 8'h01) inv = c;
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            sbox_t[b]  = 8'(s);
            isbox_t[s] = 8'(b);
        end
    endtask

    function automatic logic [DW-1:0] ref_word(input logic [DW-1:0] w, input logic fwd);
        logic [DW-1:0] r;
        for (int i = 0; i < NB; i++)
            r[8*i +: 8] = fwd ? sbox_t[w[8*i +: 8]] : isbox_t[w[8*i +: 8]];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 0; in_ready = 1; in_data = '0;
        step(); step();
        #2;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_chk++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data); end
        n_chk++; if (out_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", out_ready); end
        step();
        rst = 0;
    endtask

    task automatic test_directed();
        logic [DW-1:0] vin [2];
        logic [DW-1:0] vout[2];
        vin[0] = 32'h637C01FE; vout[0] = 32'h0001090C;
        vin[1] = 32'h00ED0000; vout[1] = 32'h52535252;
        in_ready = 1;
        for (int v = 0; v < 2; v++) begin
            in_valid = 1; in_data = vin[v];
            #2;
            n_chk++; if (out_ready !== 1'b1) begin n_fail++; $display("FAIL dir_ready[%0d]: got %b want 1", v, out_ready); end
            step();
            in_valid = 0;
            for (int c = 1; c <= 3; c++) begin
                #2;
                if (c < 3) begin
                    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir_early[%0d] c%0d: got %b want 0", v, c, out_valid); end
                end else begin
                    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir_lat[%0d]: got %b want 1", v, out_valid); end
                    n_chk++; if (out_data !== vout[v]) begin n_fail++; $display("FAIL dir_data[%0d]: got %h want %h", v, out_data, vout[v]); end
                end
                step();
            end
            #2;
            n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir_after[%0d]: got %b want 0", v, out_valid); end
        end
    endtask

    task automatic test_exhaustive();
        in_ready = 1;
        for (int c = 0; c <= 259; c++) begin
            logic [7:0] b;
            b = 8'(c);
            in_valid = (c < 256);
            in_data  = {NB{b}};
            #2;
            if (c < 256) begin
                n_chk++; if (out_ready !== 1'b1) begin n_fail++; $display("FAIL exh_ready c%0d: got %b want 1", c, out_ready); end
            end
            if (c >= 3 && c < 259) begin
                logic [DW-1:0] e;
                logic [7:0]    pb;
                pb = 8'(c - 3);
                e  = ref_word({NB{pb}}, 1'b0);
                n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL exh_valid byte %h: got %b want 1", pb, out_valid); end
                n_chk++; if (out_data !== e) begin n_fail++; $display("FAIL exh_data byte %h: got %h want %h", pb, out_data, e); end
            end
            if (c == 259) begin
                n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL exh_tail: got %b want 0", out_valid); end
            end
            step();
        end
        in_valid = 0;
    endtask

    task automatic test_stall();
        logic [DW-1:0] w [5];
        int idx;
        for (int i = 0; i < 5; i++) w[i] = $urandom;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            in_ready = (c >= 6);
            in_valid = (idx < 5);
            in_data  = w[idx < 5 ? idx : 4];
            #2;
            if (c < 3) begin
                n_chk++; if (out_ready !== 1'b1) begin n_fail++; $display("FAIL stall_acc c%0d: got %b want 1", c, out_ready); end
            end else if (c < 6) begin
                n_chk++; if (out_ready !== 1'b0) begin n_fail++; $display("FAIL stall_refuse c%0d: got %b want 0", c, out_ready); end
                n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid c%0d: got %b want 1", c, out_valid); end
                n_chk++; if (out_data !== ref_word(w[0], 1'b0)) begin n_fail++; $display("FAIL stall_hold c%0d: got %h want %h", c, out_data, ref_word(w[0], 1'b0)); end
            end else if (c <= 10) begin
                n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_drain_valid c%0d: got %b want 1", c, out_valid); end
                n_chk++; if (out_data !== ref_word(w[c-6], 1'b0)) begin n_fail++; $display("FAIL stall_drain_data c%0d: got %h want %h", c, out_data, ref_word(w[c-6], 1'b0)); end
            end else begin
                n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_empty: got %b want 0", out_valid); end
            end
            if (in_valid && out_ready) idx++;
            step();
        end
        in_valid = 0;
        n_chk++; if (idx != 5) begin n_fail++; $display("FAIL stall_count: got %0d want 5", idx); end
    endtask

    task automatic test_random_backpressure();
        logic [DW-1:0] sb[$];
        logic [DW-1:0] prev_out, e;
        logic          pending, prev_stall, exp_rdy;
        pending = 0; prev_stall = 0; prev_out = '0;
        in_valid = 0;
        for (int c = 0; c < 10000; c++) begin
            if (!pending) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = $urandom;
            end
            in_ready = ($urandom_range(0, 2) != 0);
            #2;
            // Three slots: only a full pipe facing a stalled consumer refuses a word
            exp_rdy = !(sb.size() == 3 && !in_ready);
            n_chk++; if (out_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", c, out_ready, exp_rdy); end
            if (prev_stall) begin
                n_chk++; if (out_data !== prev_out) begin n_fail++; $display("FAIL rnd_hold c%0d: got %h want %h", c, out_data, prev_out); end
            end
            if (out_valid && in_ready) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL rnd_extra c%0d: got %h want none", c, out_data);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e) begin n_fail++; $display("FAIL rnd_data c%0d: got %h want %h", c, out_data, e); end
                end
            end
            if (in_valid && out_ready) sb.push_back(ref_word(in_data, 1'b0));
            pending    = in_valid && !out_ready;
            prev_stall = out_valid && !in_ready;
            prev_out   = out_data;
            step();
        end
        in_valid = 0; in_ready = 1;
        for (int c = 0; c < 10; c++) begin
            #2;
            if (out_valid) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL rnd_drain_extra: got %h want none", out_data);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e) begin n_fail++; $display("FAIL rnd_drain_data: got %h want %h", out_data, e); end
                end
            end
            step();
        end
        n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL rnd_lost: got %0d left want 0", sb.size()); end
    endtask

    task automatic test_reset_midflight();
        in_ready = 0;
        in_valid = 1; in_data = $urandom; step();
        in_data = $urandom; step();
        in_valid = 0; rst = 1;
        #2;
        n_chk++; if (out_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_in_reset: got %b want 1", out_ready); end
        step();
        rst = 0;
        #2;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", out_valid); end
        n_chk++; if (out_data !== '0) begin n_fail++; $display("FAIL mid_data: got %h want 0", out_data); end
        in_ready = 1;
        for (int c = 0; c < 6; c++) begin
            step();
            #2;
            n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_ghost c%0d: got %b want 0", c, out_valid); end
        end
        step();
    endtask

`ifdef AES128_INV_SBOX_FWD_EN
    task automatic test_fwd();
        logic [DW-1:0] sb[$];
        logic [DW-1:0] e;
        in_ready = 1;
        in_fwd = 1; in_valid = 1; in_data = 32'h00010C53;
        step();
        in_valid = 0; in_fwd = 0;
        step(); step();
        #2;
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fwd_valid: got %b want 1", out_valid); end
        n_chk++; if (out_data !== 32'h637CFEED) begin n_fail++; $display("FAIL fwd_data: got %h want 637cfeed", out_data); end
        step();
        for (int c = 0; c < 45; c++) begin
            in_valid = (c < 40);
            in_fwd   = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            #2;
            if (out_valid) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL fwd_mix_extra c%0d: got %h want none", c, out_data);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e) begin n_fail++; $display("FAIL fwd_mix c%0d: got %h want %h", c, out_data, e); end
                end
            end
            if (in_valid && out_ready) sb.push_back(ref_word(in_data, in_fwd));
            step();
        end
        in_valid = 0; in_fwd = 0;
        n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL fwd_mix_lost: got %0d want 0", sb.size()); end
    endtask
`endif

    initial begin
        rst = 1; in_valid = 0; in_ready = 1; in_data = '0;
`ifdef AES128_INV_SBOX_FWD_EN
        in_fwd = 0;
`endif
        build_tables();
        test_reset();
        test_directed();
        test_exhaustive();
        test_stall();
        test_random_backpressure();
        test_reset_midflight();
`ifdef AES128_INV_SBOX_FWD_EN
        test_fwd();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
